// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - round-robin Ethernet TX frame arbiter with IFG enforcement
module eth_tx_arb #(
   parameter int N         = 4,
   parameter int IFG_TICKS = 12,
   parameter int MAX_LEN   = 1526,
   parameter int TIMEOUT   = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   val_in,
   input  logic [N*8-1:0] dat_in,
   output logic [N-1:0]   grant,
   output logic           out_val,
   output logic [7:0]     out_dat,
   output logic           busy,
   output logic           err
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, IFG} state_t;

   state_t         state_q;
   logic [PW-1:0]  ptr_q;
   logic [PW-1:0]  winner_d;
   logic [PW-1:0]  idx;
   logic [N-1:0]   grant_q;
   logic           out_val_q;
   logic [7:0]     out_dat_q;
   logic           err_q;
   logic [15:0]    cnt_q;
   logic [15:0]    tmr_q;
   logic [7:0]     ifg_q;
   logic           sel_val;
   logic [7:0]     sel_dat;

   // Descending scan so the nearest requester after the pointer wins.
   always_comb begin
      winner_d = ptr_q;
      idx      = '0;
      for (int k = N; k >= 1; k--) begin
         idx = PW'((int'(ptr_q) + k) % N);
         if (req[idx]) winner_d = idx;
      end
   end

   // ptr_q doubles as the current winner once granted.
   assign sel_val = val_in[ptr_q];
   assign sel_dat = dat_in[{ptr_q, 3'b000} +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= PW'(N - 1);
         grant_q   <= '0;
         out_val_q <= 1'b0;
         out_dat_q <= 8'd0;
         err_q     <= 1'b0;
         cnt_q     <= 16'd0;
         tmr_q     <= 16'd0;
         ifg_q     <= 8'd0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               out_val_q <= 1'b0;
               out_dat_q <= 8'd0;
               if (|req) begin
                  ptr_q   <= winner_d;
                  grant_q <= N'(1) << winner_d;
                  tmr_q   <= 16'd0;
                  cnt_q   <= 16'd0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (sel_val) begin
                  out_val_q <= 1'b1;
                  out_dat_q <= sel_dat;
                  cnt_q     <= 16'd1;
                  state_q   <= ACTIVE;
               end else if (tmr_q == 16'(TIMEOUT - 1)) begin
                  grant_q <= '0;
                  err_q   <= 1'b1;
                  ifg_q   <= 8'd0;
                  state_q <= IFG;
               end else begin
                  tmr_q <= tmr_q + 16'd1;
               end
            end
            ACTIVE: begin
               if (!sel_val || cnt_q == 16'(MAX_LEN)) begin
                  // Frame end and truncation share the IFG path; only truncation flags err.
                  out_val_q <= 1'b0;
                  out_dat_q <= 8'd0;
                  grant_q   <= '0;
                  err_q     <= sel_val;
                  ifg_q     <= 8'd0;
                  state_q   <= IFG;
               end else begin
                  out_val_q <= 1'b1;
                  out_dat_q <= sel_dat;
                  cnt_q     <= cnt_q + 16'd1;
               end
            end
            IFG: begin
               out_val_q <= 1'b0;
               out_dat_q <= 8'd0;
               if (ifg_q == 8'(IFG_TICKS - 1)) state_q <= IDLE;
               else ifg_q <= ifg_q + 8'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant   = grant_q;
   assign out_val = out_val_q;
   assign out_dat = out_dat_q;
   assign err     = err_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - scoreboard bench for eth_tx_arb (MAX_LEN=8)
module tb_eth_tx_arb;

   localparam int N = 4;
   localparam int IFG = 12;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   val_in;
   logic [N*8-1:0] dat_in;
   logic [N-1:0]   grant;
   logic           out_val;
   logic [7:0]     out_dat;
   logic           busy;
   logic           err;

   eth_tx_arb #(.N(N), .IFG_TICKS(IFG), .MAX_LEN(8), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req(req), .val_in(val_in), .dat_in(dat_in),
      .grant(grant), .out_val(out_val), .out_dat(out_dat), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int err_cnt = 0;
   logic [7:0] bq[$];
   logic [N-1:0] gq[$];
   logic [7:0] fr [0:15];

   task automatic chk(input bit ok, input string name, input int got, input int exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Byte / grant / err monitors, all sampled on the falling edge.
   logic [N-1:0] prev_grant = '0;
   int zeros = 0;
   bit armed = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_grant = '0;
         armed = 1'b0;
         zeros = 0;
      end else begin
         if (out_val) begin
            if (bq.size() == 0) chk(1'b0, "unexpected_byte", out_dat, 0);
            else begin
               logic [7:0] e;
               e = bq.pop_front();
               chk(out_dat == e, "out_dat", out_dat, e);
            end
            if (armed && zeros > 0) chk(zeros >= IFG, "ifg_gap", zeros, IFG);
            zeros = 0;
            armed = 1'b1;
         end else begin
            chk(out_dat == 8'd0, "out_dat_idle_zero", out_dat, 0);
            zeros++;
         end
         if (grant != prev_grant && grant != '0) begin
            if (gq.size() == 0) chk(1'b0, "unexpected_grant", grant, 0);
            else begin
               logic [N-1:0] g;
               g = gq.pop_front();
               chk(grant == g, "grant_order", grant, g);
            end
         end
         prev_grant = grant;
         if (err) err_cnt++;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int src);
      int n = 0;
      while (grant != (N'(1) << src) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(grant == (N'(1) << src), "wait_grant", grant, N'(1) << src);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk(!busy, "wait_idle", busy, 0);
   endtask

   // Drives n bytes from fr[] on src; only the first nexp are expected downstream.
   task automatic send(input int src, input int n, input int nexp, input bit noise);
      for (int k = 0; k < n; k++) begin
         val_in[src] = 1'b1;
         dat_in[src*8 +: 8] = fr[k];
         if (noise) begin
            val_in[3] = k[0];
            dat_in[31:24] = 8'hEE;
         end
         if (k < nexp) bq.push_back(fr[k]);
         @(posedge clk); #1;
      end
      val_in = '0;
      dat_in = '0;
   endtask

   initial begin
      int e0;
      int n;
      rst = 1'b1;
      req = '0;
      val_in = '0;
      dat_in = '0;
      #3;
      chk(grant == '0, "rst_grant", grant, 0);
      chk(out_val == 1'b0, "rst_out_val", out_val, 0);
      chk(out_dat == 8'd0, "rst_out_dat", out_dat, 0);
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(err == 1'b0, "rst_err", err, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single frame from source 1
      gq.push_back(4'b0010);
      req = 4'b0010;
      @(posedge clk); #1;
      chk(grant == 4'b0010, "t1_grant_latency", grant, 4'b0010);
      req = '0;
      fr[0] = 8'h55; fr[1] = 8'h55; fr[2] = 8'hD5;
      for (int k = 0; k < 3; k++) begin
         val_in[1] = 1'b1;
         dat_in[15:8] = fr[k];
         bq.push_back(fr[k]);
         @(posedge clk); #1;
         chk(out_val && out_dat == fr[k], "t1_byte_latency", out_dat, fr[k]);
      end
      val_in = '0;
      dat_in = '0;
      n = 0;
      while (out_val && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      chk(n == IFG, "t1_ifg_cycles", n, IFG);
      @(posedge clk); #1;

      // Contention: all four request continuously
      do_reset();
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         int s;
         s = f % 4;
         gq.push_back(N'(1) << s);
         wait_grant(s);
         for (int k = 0; k < 4; k++) fr[k] = 8'(s * 16 + k + 1);
         if (f == 4) req = '0;
         send(s, 4, 4, 1'b0);
      end
      req = '0;
      wait_idle();

      // Timeout on source 2
      do_reset();
      e0 = err_cnt;
      gq.push_back(4'b0100);
      req = 4'b0100;
      wait_grant(2);
      req = '0;
      n = 0;
      while (grant != '0 && n < 200) begin n++; @(posedge clk); #1; end
      chk(n == 64, "t3_timeout_cycles", n, 64);
      wait_idle();
      chk(err_cnt - e0 == 1, "t3_err_pulses", err_cnt - e0, 1);

      // Truncation: 10 bytes sent, 8 forwarded
      do_reset();
      e0 = err_cnt;
      gq.push_back(4'b0001);
      req = 4'b0001;
      wait_grant(0);
      req = '0;
      for (int k = 0; k < 10; k++) fr[k] = 8'(8'hA0 + k);
      send(0, 10, 8, 1'b0);
      chk(grant == '0, "t4_grant_dropped", grant, 0);
      chk(busy == 1'b1, "t4_in_ifg", busy, 1);
      wait_idle();
      chk(err_cnt - e0 == 1, "t4_err_pulses", err_cnt - e0, 1);

      // Isolation: source 3 toggles val while source 0 is granted
      do_reset();
      e0 = err_cnt;
      gq.push_back(4'b0001);
      req = 4'b0001;
      wait_grant(0);
      req = '0;
      for (int k = 0; k < 5; k++) fr[k] = 8'(8'h30 + k);
      send(0, 5, 5, 1'b1);
      wait_idle();
      chk(err_cnt == e0, "t5_no_err", err_cnt - e0, 0);

      // Reset mid-frame at byte 5
      do_reset();
      gq.push_back(4'b0001);
      req = 4'b0001;
      wait_grant(0);
      req = '0;
      for (int k = 0; k < 5; k++) begin
         val_in[0] = 1'b1;
         dat_in[7:0] = 8'(8'h40 + k);
         bq.push_back(8'(8'h40 + k));
         if (k < 4) begin @(posedge clk); #1; end
      end
      #2 rst = 1'b1;
      #1;
      chk(out_val == 1'b0, "t6_async_out_val", out_val, 0);
      chk(grant == '0, "t6_async_grant", grant, 0);
      chk(busy == 1'b0, "t6_async_busy", busy, 0);
      bq.delete();
      val_in = '0;
      dat_in = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      gq.push_back(4'b0001);
      req = 4'b1001;
      @(posedge clk); #1;
      chk(grant == 4'b0001, "t6_post_reset_grant", grant, 4'b0001);
      req = '0;
      fr[0] = 8'h11; fr[1] = 8'h22;
      send(0, 2, 2, 1'b0);
      wait_idle();
      repeat (2) @(posedge clk);
      #1;

      chk(bq.size() == 0, "bytes_outstanding", bq.size(), 0);
      chk(gq.size() == 0, "grants_outstanding", gq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
